dmem_store_rmw: RTL and testbench

Store-side counterpart of the load extraction path in the RISCV64 data-memory interface. It accepts one store request per handshake, reads the containing 64-bit memory word, merges the store data into the addressed lane, and writes the word back. The memory port has no byte enables. The block sits between the execute/memory stage and the data memory. Its lane selection and the size-111 halfword swap are the exact inverse of the load path, so a store followed by a load of the same size and address returns the original data.

---
 rtl/dmem_store_rmw_pkg.sv | 22 ++
 rtl/dmem_lane_merge.sv | 28 ++
 rtl/dmem_store_rmw.sv | 102 ++++++++++
 tb/tb_dmem_store_rmw.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_store_rmw_pkg.sv
// Shared definitions for the data-memory store path: access-size codes and FSM states.
package dmem_store_rmw_pkg;

  localparam int unsigned DMEM_DATA_BITS = 64;

  localparam logic [2:0] SIZE_B   = 3'b000;
  localparam logic [2:0] SIZE_H   = 3'b001;
  localparam logic [2:0] SIZE_W   = 3'b010;
  localparam logic [2:0] SIZE_D   = 3'b011;
  localparam logic [2:0] SIZE_BU  = 3'b100;
  localparam logic [2:0] SIZE_HU  = 3'b101;
  localparam logic [2:0] SIZE_WU  = 3'b110;
  localparam logic [2:0] SIZE_SWP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_MERGE,
    ST_WRITE
  } state_e;

endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational lane merge: replaces the addressed lane of a memory word with store data.
module dmem_lane_merge
  import dmem_store_rmw_pkg::*;
#(
  parameter int unsigned DATA_BITS = DMEM_DATA_BITS
) (
  input  logic [DATA_BITS-1:0] old_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic [2:0]           size_i,
  input  logic [2:0]           addr_i,
  input  logic                 cnt0_i,
  output logic [DATA_BITS-1:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    case (size_i)
      SIZE_B, SIZE_BU: merged_o[{addr_i, 3'b000} +: 8]        = data_i[7:0];
      SIZE_H, SIZE_HU: merged_o[{addr_i[2:1], 4'b0000} +: 16] = data_i[15:0];
      SIZE_W, SIZE_WU: merged_o[{addr_i[2], 5'b00000} +: 32]  = data_i[31:0];
      SIZE_D:          merged_o = data_i;
      // Halves swapped so a size-111 load of this lane returns the original data.
      SIZE_SWP:        merged_o[{cnt0_i, 5'b00000} +: 32] = {data_i[15:0], data_i[31:16]};
      default:         merged_o = old_i;
    endcase
  end

endmodule

// File: rtl/dmem_store_rmw.sv
// Store read-modify-write engine: reads the containing word, merges the store lane, writes it back.
module dmem_store_rmw
  import dmem_store_rmw_pkg::*;
#(
  parameter int unsigned DATA_BITS = DMEM_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_size,
  input  logic [DATA_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_data,
  input  logic [DATA_BITS-1:0] req_counter,
  output logic                 done,
  output logic [DATA_BITS-1:0] mem_addr,
  output logic                 mem_rd_en,
  input  logic [DATA_BITS-1:0] mem_rd_data,
  output logic                 mem_wr_en,
  output logic [DATA_BITS-1:0] mem_wr_data
);

  state_e               state_q, state_d;
  logic [2:0]           size_q,  size_d;
  logic [DATA_BITS-1:0] addr_q,  addr_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 cnt0_q,  cnt0_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] merged;
  logic                 unused_counter_bits;

  assign unused_counter_bits = ^req_counter[DATA_BITS-1:1];

  dmem_lane_merge #(.DATA_BITS(DATA_BITS)) u_merge (
    .old_i    (mem_rd_data),
    .data_i   (data_q),
    .size_i   (size_q),
    .addr_i   (addr_q[2:0]),
    .cnt0_i   (cnt0_q),
    .merged_o (merged)
  );

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt0_d  = cnt0_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d = req_size;
          addr_d = req_addr;
          data_d = req_data;
          cnt0_d = req_counter[0];
          // A full dword needs no read; write-back data is loaded directly.
          if (req_size == SIZE_D) begin
            wdata_d = req_data;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ:  state_d = ST_MERGE;
      ST_MERGE: begin
        wdata_d = merged;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      size_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt0_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt0_q  <= cnt0_d;
      wdata_q <= wdata_d;
    end
  end

  // Write strobes are masked by reset so a reset landing in WRITE never commits.
  assign req_ready   = (state_q == ST_IDLE) && !rst;
  assign mem_rd_en   = (state_q == ST_READ);
  assign mem_wr_en   = (state_q == ST_WRITE) && !rst;
  assign done        = (state_q == ST_WRITE) && !rst;
  assign mem_addr    = {addr_q[DATA_BITS-1:3], 3'b000};
  assign mem_wr_data = wdata_q;

endmodule

// File: tb/tb_dmem_store_rmw.sv
// Directed bench for dmem_store_rmw with a small registered-read memory model.
module tb_dmem_store_rmw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_size = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic [63:0] req_counter = '0;
  logic        done;
  logic [63:0] mem_addr;
  logic        mem_rd_en;
  logic [63:0] mem_rd_data;
  logic        mem_wr_en;
  logic [63:0] mem_wr_data;

  int total = 0;
  int bad   = 0;

  logic [63:0] mem [0:7];
  logic [63:0] rd_q = '0;
  int          rd_total = 0;
  int          wr_total = 0;
  logic        pl_en = 1'b0;
  logic [2:0]  pl_idx = '0;
  logic [63:0] pl_val = '0;

  int          rf, rn, wn, dc, rd0, wr0;
  logic [63:0] wd;
  logic        r2;

  localparam logic [63:0] INIT = 64'h1122334455667788;

  always #5 clk = ~clk;

  dmem_store_rmw #(.DATA_BITS(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_size    (req_size),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_counter (req_counter),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  assign mem_rd_data = rd_q;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      rd_q     <= mem[mem_addr[5:3]];
      rd_total <= rd_total + 1;
    end
    if (mem_wr_en) begin
      mem[mem_addr[5:3]] <= mem_wr_data;
      wr_total           <= wr_total + 1;
    end
    if (pl_en) mem[pl_idx] <= pl_val;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [63:0] a, input logic [63:0] v);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = a[5:3];
    pl_val = v;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  function automatic logic [31:0] load_swp(input logic [63:0] w, input logic c);
    logic [31:0] lane;
    lane = c ? w[63:32] : w[31:0];
    return {lane[15:0], lane[31:16]};
  endfunction

  // Issues one request and observes cycles 1..5 after the accept edge.
  task automatic run_store(input logic [2:0] sz, input logic [63:0] a, input logic [63:0] d,
                           input logic c);
    @(negedge clk);
    chk("ready_before", {63'd0, req_ready}, 64'd1);
    req_valid   = 1'b1;
    req_size    = sz;
    req_addr    = a;
    req_data    = d;
    req_counter = {63'd0, c};
    @(posedge clk);
    #1 req_valid = 1'b0;
    rf = -1; rn = 0; wn = 0; dc = -1; wd = '0; r2 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        rn++;
        if (rf < 0) rf = k;
      end
      if (mem_wr_en) begin
        wn++;
        wd = mem_wr_data;
      end
      if (done && dc < 0) dc = k;
      if (k == 2) r2 = req_ready;
    end
  endtask

  task automatic st_check(input string t, input logic [2:0] sz, input logic [63:0] a,
                          input logic [63:0] d, input logic c, input logic [63:0] expw);
    run_store(sz, a, d, c);
    chk({t, "_rd_cycle"}, 64'(rf), 64'd1);
    chk({t, "_rd_count"}, 64'(rn), 64'd1);
    chk({t, "_wr_count"}, 64'(wn), 64'd1);
    chk({t, "_done_cycle"}, 64'(dc), 64'd3);
    chk({t, "_wr_data"}, wd, expw);
    chk({t, "_mem"}, mem[a[5:3]], expw);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
    chk("rst_wr_en", {63'd0, mem_wr_en}, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wr_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, req_ready}, 64'd1);

    preload(64'h100, INIT);
    st_check("byte", 3'b000, 64'h103, 64'h0000_0000_0000_00AB, 1'b0, 64'h11223344AB667788);
    preload(64'h100, INIT);
    st_check("half_u", 3'b101, 64'h107, 64'h0000_0000_FFFF_BEEF, 1'b0, 64'hBEEF334455667788);
    preload(64'h100, INIT);
    st_check("word", 3'b010, 64'h104, 64'h0000_0000_DEAD_BEEF, 1'b0, 64'hDEADBEEF55667788);
    preload(64'h100, INIT);
    st_check("byte_lane0", 3'b100, 64'h100, 64'h0000_0000_0000_01FF, 1'b0, 64'h11223344556677FF);
    preload(64'h100, INIT);
    st_check("byte_lane7", 3'b000, 64'h107, 64'h0000_0000_0000_0000, 1'b0, 64'h0022334455667788);
    preload(64'h100, INIT);
    st_check("word_lane0_unal", 3'b110, 64'h103, 64'h0000_0000_CAFE_F00D, 1'b0, 64'h11223344CAFEF00D);

    // Dword: no read, write at cycle 1, ready again at cycle 2
    preload(64'h100, INIT);
    run_store(3'b011, 64'h100, 64'h0123456789ABCDEF, 1'b0);
    chk("dword_rd_count", 64'(rn), 64'd0);
    chk("dword_wr_count", 64'(wn), 64'd1);
    chk("dword_done_cycle", 64'(dc), 64'd1);
    chk("dword_ready_c2", {63'd0, r2}, 64'd1);
    chk("dword_wr_data", wd, 64'h0123456789ABCDEF);
    chk("dword_mem", mem[0], 64'h0123456789ABCDEF);

    // Swapped-halves word, both lanes, then read back through the load inverse
    preload(64'h100, INIT);
    st_check("swp_c1", 3'b111, 64'h100, 64'h0000_0000_AAAA_BBBB, 1'b1, 64'hBBBBAAAA55667788);
    chk("swp_c1_load", {32'd0, load_swp(mem[0], 1'b1)}, 64'h0000_0000_AAAA_BBBB);
    preload(64'h100, INIT);
    st_check("swp_c0", 3'b111, 64'h100, 64'h0000_0000_AAAA_BBBB, 1'b0, 64'h11223344BBBBAAAA);
    chk("swp_c0_load", {32'd0, load_swp(mem[0], 1'b0)}, 64'h0000_0000_AAAA_BBBB);

    // Reset during MERGE: no write, memory untouched
    preload(64'h100, INIT);
    wr0 = wr_total;
    @(negedge clk);
    req_valid = 1'b1; req_size = 3'b000; req_addr = 64'h102; req_data = 64'h5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("midrst_ready_in_rst", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_ready_after", {63'd0, req_ready}, 64'd1);
    chk("midrst_wr_en", {63'd0, mem_wr_en}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_wr_total", 64'(wr_total - wr0), 64'd0);
    chk("midrst_mem", mem[0], INIT);

    // Requests presented during READ/MERGE are ignored
    preload(64'h100, INIT);
    preload(64'h108, 64'hCAFEBABE00000000);
    rd0 = rd_total;
    wr0 = wr_total;
    @(negedge clk);
    req_valid = 1'b1; req_size = 3'b000; req_addr = 64'h100; req_data = 64'h99;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_size = 3'b011; req_addr = 64'h108; req_data = '0;
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ign_wr_en", {63'd0, mem_wr_en}, 64'd1);
    chk("ign_addr", mem_addr, 64'h100);
    chk("ign_wdata", mem_wr_data, 64'h1122334455667799);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("ign_rd_total", 64'(rd_total - rd0), 64'd1);
    chk("ign_wr_total", 64'(wr_total - wr0), 64'd1);
    chk("ign_other_mem", mem[1], 64'hCAFEBABE00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
